funct_generator_fifo: RTL and testbench
=======================================

FUNCT_GENERATOR_FIFO -- requirements
Module: funct_generator_fifo

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the sample width in signed fixed point with 4 integer bits, declared [3:4-DATA_WIDTH].
REQ-002 The block SHALL have parameter DEPTH, default 16, giving the number of entries; it must be a power of 2 and at least 2.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port clear_i, input, 1 bit: synchronous flush.
REQ-006 The block SHALL have port wr_en_i, input, 1 bit: push request, driven by the sample tick.
REQ-007 The block SHALL have port data_i, input, signed [3:4-DATA_WIDTH]: sample from the function-generator multiplexer output.
REQ-008 The block SHALL have port rd_en_i, input, 1 bit: pop request from the consumer.
REQ-009 The block SHALL have port data_o, output, signed [3:4-DATA_WIDTH]: registered popped sample.
REQ-010 The block SHALL have port valid_o, output, 1 bit: one-cycle strobe marking data_o as updated.
REQ-011 The block SHALL have port full_o, output, 1 bit: count equals DEPTH.
REQ-012 The block SHALL have port empty_o, output, 1 bit: count equals 0.
REQ-013 The block SHALL have port count_o, output, $clog2(DEPTH)+1 bits: current occupancy.
REQ-014 The block SHALL have port overflow_o, output, 1 bit: sticky flag for a rejected push.
REQ-015 The block SHALL have port underflow_o, output, 1 bit: sticky flag for a rejected pop.

Function
REQ-016 Storage SHALL be a DEPTH-entry circular buffer with wr_ptr and rd_ptr of $clog2(DEPTH) bits each; both pointers wrap from DEPTH-1 to 0.
REQ-017 A push SHALL be accepted when wr_en_i=1 and (full_o=0 or an accepted pop occurs in the same cycle); data_i is written at wr_ptr, and wr_ptr increments.
REQ-018 A pop SHALL be accepted when rd_en_i=1 and empty_o=0; mem[rd_ptr] is registered into data_o, rd_ptr increments, and valid_o=1 on the following cycle.
REQ-019 Read latency SHALL be 1 cycle from an accepted rd_en_i to valid_o/data_o; data_o holds its last value when no pop occurs; valid_o=0 otherwise.
REQ-020 The FIFO SHALL have no fall-through: with empty_o=1, a simultaneous push and pop accepts the push only; the pop is rejected and count becomes 1.
REQ-021 With full_o=1, a simultaneous push and pop SHALL both be accepted, leave count unchanged, and leave full_o=1.
REQ-022 count_o SHALL be +1 on push only, -1 on pop only, and unchanged on both or neither; full_o and empty_o are derived combinationally from the registered count.
REQ-023 wr_en_i while full_o=1 without an accepted pop SHALL discard the sample, leave the stored contents unchanged, and set overflow_o to 1.
REQ-024 rd_en_i while empty_o=1 SHALL set underflow_o to 1 and leave data_o unchanged with valid_o=0.
REQ-025 overflow_o and underflow_o SHALL remain 1 until rst or clear_i.
REQ-026 clear_i=1 SHALL, at the next edge, zero both pointers and count, clear both sticky flags, and force valid_o=0; it has priority over push and pop in the same cycle, and data_o and memory contents are retained.
REQ-027 Sample values SHALL be stored bit-exact: no saturation, rounding, or sign manipulation.

Reset
REQ-028 While rst=1, asynchronously: wr_ptr=0, rd_ptr=0, count_o=0, empty_o=1, full_o=0, valid_o=0, data_o=0, overflow_o=0, underflow_o=0.
REQ-029 Memory contents SHALL NOT require reset; no stale entry is readable after reset because count=0.
REQ-030 Reset asserted mid-operation (partially full, pop in flight) SHALL abort that pop: valid_o=0 and data_o=0 while rst=1, and the first post-reset push/pop behaves as from empty.

Verification (DEPTH=4, DATA_WIDTH=32)
REQ-031 Bench scenario: reset, push 0x10000000, 0xF0000000, 0x08000000, then pop 3 -> data_o sequence is 0x10000000, 0xF0000000, 0x08000000, each with valid_o=1 exactly one cycle after rd_en_i; empty_o=1 afterwards.
REQ-032 Bench scenario: push 5 samples A..E without popping -> full_o=1 after the 4th push, overflow_o=1 after E, count_o=4; popping 4 returns A..D.
REQ-033 Bench scenario: fill to 4, then push F and pop simultaneously for 6 cycles -> count_o stays 4, overflow_o=0, and the pointers wrap with output order preserved.
REQ-034 Bench scenario: empty FIFO, push G and pop in the same cycle -> count_o=1, valid_o=0, underflow_o=1; the next pop returns G.
REQ-035 Bench scenario: 3 entries stored, assert clear_i together with wr_en_i -> count_o=0, empty_o=1, flags 0, and the push is discarded.
REQ-036 Bench scenario: 2 entries stored, rst pulse asynchronous to clk during an rd_en_i cycle -> all outputs take their reset values immediately, and no valid_o follows.

Source files
------------

// File: rtl/funct_generator_fifo.sv
// Sample FIFO between the function-generator multiplexer and its consumer.
// Registered pop output with a one-cycle valid strobe and sticky error flags.
module funct_generator_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear_i,
  input  logic                          wr_en_i,
  input  logic signed [3:4-DATA_WIDTH]  data_i,
  input  logic                          rd_en_i,
  output logic signed [3:4-DATA_WIDTH]  data_o,
  output logic                          valid_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(DEPTH):0]        count_o,
  output logic                          overflow_o,
  output logic                          underflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic signed [3:4-DATA_WIDTH] r_mem [DEPTH];
  logic [AW-1:0]                r_wr_ptr;
  logic [AW-1:0]                r_rd_ptr;
  logic [CW-1:0]                r_count;
  logic signed [3:4-DATA_WIDTH] r_data;
  logic                         r_valid;
  logic                         r_overflow;
  logic                         r_underflow;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  // A pop frees a slot in the same cycle, so a full FIFO still takes the push.
  assign w_pop   = rd_en_i & ~w_empty;
  assign w_push  = wr_en_i & (~w_full | w_pop);

  // Storage carries no reset; occupancy alone decides what is readable.
  always_ff @(posedge clk) begin
    if (w_push && !clear_i) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (clear_i) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_valid     <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_valid <= w_pop;
      if (w_pop) begin
        r_data   <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
      if (wr_en_i && !w_push) begin
        r_overflow <= 1'b1;
      end
      if (rd_en_i && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign data_o      = r_data;
  assign valid_o     = r_valid;
  assign full_o      = w_full;
  assign empty_o     = w_empty;
  assign count_o     = r_count;
  assign overflow_o  = r_overflow;
  assign underflow_o = r_underflow;

endmodule

// File: tb/tb_funct_generator_fifo.sv
// Directed bench for funct_generator_fifo: queue-based reference model checked
// every falling edge, plus literal expectations for each scenario.
module tb_funct_generator_fifo;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 clear_i = 1'b0;
  logic                 wr_en_i = 1'b0;
  logic signed [3:4-DW] data_i = '0;
  logic                 rd_en_i = 1'b0;
  logic signed [3:4-DW] data_o;
  logic                 valid_o;
  logic                 full_o;
  logic                 empty_o;
  logic [2:0]           count_o;
  logic                 overflow_o;
  logic                 underflow_o;

  funct_generator_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clear_i(clear_i), .wr_en_i(wr_en_i),
    .data_i(data_i), .rd_en_i(rd_en_i), .data_o(data_o), .valid_o(valid_o),
    .full_o(full_o), .empty_o(empty_o), .count_o(count_o),
    .overflow_o(overflow_o), .underflow_o(underflow_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of stored samples plus the observable registers.
  logic [31:0] mq[$];
  logic [31:0] m_data  = '0;
  logic        m_valid = 1'b0;
  logic        m_over  = 1'b0;
  logic        m_under = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_data  <= '0;
      m_valid <= 1'b0;
      m_over  <= 1'b0;
      m_under <= 1'b0;
    end else if (clear_i) begin
      mq.delete();
      m_valid <= 1'b0;
      m_over  <= 1'b0;
      m_under <= 1'b0;
    end else begin
      bit pop_ok, push_ok;
      pop_ok  = rd_en_i && (mq.size() > 0);
      push_ok = wr_en_i && ((mq.size() < DEPTH) || pop_ok);
      if (rd_en_i && mq.size() == 0) m_under <= 1'b1;
      if (wr_en_i && !push_ok)       m_over  <= 1'b1;
      m_valid <= pop_ok;
      if (pop_ok)  m_data <= mq.pop_front();
      if (push_ok) mq.push_back(data_i);
    end
  end

  logic [31:0] got[$];

  always @(negedge clk) begin
    chk("count",     32'(count_o),     32'(mq.size()));
    chk("empty",     32'(empty_o),     32'(mq.size() == 0));
    chk("full",      32'(full_o),      32'(mq.size() == DEPTH));
    chk("valid",     32'(valid_o),     32'(m_valid));
    chk("data",      data_o,           m_data);
    chk("overflow",  32'(overflow_o),  32'(m_over));
    chk("underflow", 32'(underflow_o), 32'(m_under));
    if (valid_o) got.push_back(data_o);
  end

  // Drive one cycle of inputs, let the edge happen, return just after the falling edge.
  task automatic step(input bit wr, input logic [31:0] d, input bit rd, input bit clr);
    wr_en_i = wr; data_i = d; rd_en_i = rd; clear_i = clr;
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("txn wr=%0b d=%h rd=%0b clr=%0b -> cnt=%0d v=%0b q=%h ov=%0b un=%0b",
             wr, d, rd, clr, count_o, valid_o, data_o, overflow_o, underflow_o);
    wr_en_i = 1'b0; rd_en_i = 1'b0; clear_i = 1'b0;
  endtask

  initial begin
    logic [31:0] pat[6];
    logic [31:0] fill[10];
    rst = 1'b1;
    #2;
    chk("rst_count", 32'(count_o), 0);
    chk("rst_empty", 32'(empty_o), 1);
    chk("rst_full",  32'(full_o),  0);
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_data",  data_o,       0);
    @(negedge clk); #1;
    rst = 1'b0;

    // Ordered push then pop, including a negative sample.
    got.delete();
    step(1, 32'h10000000, 0, 0);
    step(1, 32'hF0000000, 0, 0);
    step(1, 32'h08000000, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    chk("s1_n",  got.size(), 3);
    chk("s1_d0", got[0], 32'h10000000);
    chk("s1_d1", got[1], 32'hF0000000);
    chk("s1_d2", got[2], 32'h08000000);
    chk("s1_empty", 32'(empty_o), 1);

    // Overfill: the fifth push is dropped and flagged.
    pat = '{32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003, 32'hDDDD0004, 32'hEEEE0005, 0};
    got.delete();
    for (int i = 0; i < 4; i++) step(1, pat[i], 0, 0);
    chk("s2_full4", 32'(full_o), 1);
    step(1, pat[4], 0, 0);
    chk("s2_over",  32'(overflow_o), 1);
    chk("s2_count", 32'(count_o), 4);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    chk("s2_n", got.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("s2_d%0d", i), got[i], pat[i]);
    step(0, 0, 0, 1);

    // Full FIFO streaming: simultaneous push/pop wraps both pointers.
    for (int i = 0; i < 10; i++) fill[i] = 32'h70000000 + 32'(i * 32'h01010101);
    got.delete();
    for (int i = 0; i < 4; i++) step(1, fill[i], 0, 0);
    for (int i = 4; i < 10; i++) step(1, fill[i], 1, 0);
    chk("s3_count", 32'(count_o), 4);
    chk("s3_over",  32'(overflow_o), 0);
    step(0, 0, 0, 0);
    chk("s3_n", got.size(), 6);
    for (int i = 0; i < 6; i++) chk($sformatf("s3_d%0d", i), got[i], fill[i]);
    step(0, 0, 0, 1);

    // No fall-through from empty.
    got.delete();
    step(1, 32'h9ABCDEF0, 1, 0);
    chk("s4_count", 32'(count_o), 1);
    chk("s4_valid", 32'(valid_o), 0);
    chk("s4_under", 32'(underflow_o), 1);
    step(0, 0, 1, 0);
    chk("s4_n", got.size(), 1);
    chk("s4_g", got[0], 32'h9ABCDEF0);
    step(0, 0, 0, 1);

    // Clear wins over a concurrent push.
    for (int i = 0; i < 3; i++) step(1, 32'h01230000 + 32'(i), 0, 0);
    step(1, 32'h0BADF00D, 0, 1);
    chk("s5_count", 32'(count_o), 0);
    chk("s5_empty", 32'(empty_o), 1);
    chk("s5_over",  32'(overflow_o), 0);
    chk("s5_under", 32'(underflow_o), 0);

    // Asynchronous reset in the middle of a pop cycle.
    step(1, 32'h22220001, 0, 0);
    step(1, 32'h22220002, 0, 0);
    rd_en_i = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("s6_count", 32'(count_o), 0);
    chk("s6_empty", 32'(empty_o), 1);
    chk("s6_valid", 32'(valid_o), 0);
    chk("s6_data",  data_o, 0);
    #1 rst = 1'b0;
    rd_en_i = 1'b0;
    @(negedge clk); #1;
    chk("s6_novalid", 32'(valid_o), 0);
    got.delete();
    step(1, 32'h33330003, 0, 0);
    chk("s6_post_count", 32'(count_o), 1);
    step(0, 0, 1, 0);
    chk("s6_post_d", got.size() == 1 ? got[0] : 32'hDEADDEAD, 32'h33330003);

    step(0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
